// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Input staging in front of an N x N output-stationary PE array. Accepts one
//   A column and one B row per beat, skews lane i by i advances, drives the
//   array-wide write enable and pads fill/drain with zeros so every PE sees
//   exactly K products per tile.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start, k_len        tile start pulse and reduction length (sampled in IDLE)
//   a_vec, b_vec        one A column / B row, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid, in_ready  beat handshake (ready only in FEED)
//   we                  array-wide write enable, aligned with a_row/b_col
//   a_row, b_col        skewed operands to the array edges
//   busy, done          tile in progress / one-cycle tile-complete pulse

// One skew lane: DEPTH delay stages followed by the output register.
// stg[DEPTH] is the output; only the stages in front of it are cleared on
// tile entry, so the output holds its last value until the first advance.
module systolic_feeder_lane #(
  parameter int DEPTH      = 0,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DEPTH:0][DATA_WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (adv) begin
      stg[0] <= din;
      for (int k = 1; k <= DEPTH; k++) stg[k] <= stg[k-1];
    end
  end

  assign dout = stg[DEPTH];
endmodule

module systolic_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int K_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  input  logic [N*DATA_WIDTH-1:0] a_vec,
  input  logic [N*DATA_WIDTH-1:0] b_vec,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    we,
  output logic [N*DATA_WIDTH-1:0] a_row,
  output logic [N*DATA_WIDTH-1:0] b_col,
  output logic                    busy,
  output logic                    done
);
  localparam int DRAIN_CYC = 2*N - 2;
  localparam int DCW       = $clog2(2*N + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q, cnt_q;
  logic [DCW-1:0] dcnt_q;
  logic           accept, adv, last_beat, drain_last, start_ok;

  logic [N-1:0][DATA_WIDTH-1:0] a_in_v, b_in_v, a_out_v, b_out_v;

  assign in_ready   = (state_q == FEED);
  assign accept     = in_valid & in_ready;
  // During DRAIN every cycle is an advance that injects zeros.
  assign adv        = accept | (state_q == DRAIN);
  // K is never zero in FEED, so K-1 cannot underflow.
  assign last_beat  = accept && (cnt_q == k_q - K_W'(1));
  assign drain_last = (state_q == DRAIN) && (dcnt_q == DCW'(DRAIN_CYC - 1));
  assign start_ok   = (state_q == IDLE) && start && (k_len != '0);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (k_len != '0) ? FEED : DONE;
      FEED:    if (last_beat) state_d = (N > 1) ? DRAIN : DONE;
      DRAIN:   if (drain_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      cnt_q  <= '0;
      dcnt_q <= '0;
      we     <= 1'b0;
    end else begin
      we <= adv;
      if (start_ok) begin
        k_q   <= k_len;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + K_W'(1);
      end
      if (state_q == DRAIN) dcnt_q <= dcnt_q + DCW'(1);
      else                  dcnt_q <= '0;
    end
  end

  // Zero injection in DRAIN pushes the last real beat out through every lane.
  assign a_in_v = (state_q == DRAIN) ? '0 : a_vec;
  assign b_in_v = (state_q == DRAIN) ? '0 : b_vec;

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_feeder_lane #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(start_ok), .adv(adv),
      .din(a_in_v[i]), .dout(a_out_v[i])
    );
    systolic_feeder_lane #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(start_ok), .adv(adv),
      .din(b_in_v[i]), .dout(b_out_v[i])
    );
  end

  assign a_row = a_out_v;
  assign b_col = b_out_v;
endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [N*DW-1:0] a_vec = '0, b_vec = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, we, busy, done;
  logic [N*DW-1:0] a_row, b_col;

  systolic_feeder #(.N(N), .DATA_WIDTH(DW), .K_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .a_vec(a_vec), .b_vec(b_vec), .in_valid(in_valid), .in_ready(in_ready),
    .we(we), .a_row(a_row), .b_col(b_col), .busy(busy), .done(done)
  );

  logic          start1 = 1'b0;
  logic [KW-1:0] k1 = '0;
  logic [DW-1:0] a1 = '0, b1 = '0;
  logic          v1 = 1'b0;
  logic          rdy1, we1, busy1, done1;
  logic [DW-1:0] ar1, bc1;

  systolic_feeder #(.N(1), .DATA_WIDTH(DW), .K_W(KW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .k_len(k1),
    .a_vec(a1), .b_vec(b1), .in_valid(v1), .in_ready(rdy1),
    .we(we1), .a_row(ar1), .b_col(bc1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tile progress as counts: beats still owed, drain advances still owed,
  // and a done flag. Every advance is logged; lane i then shows the vector
  // logged i advances ago.
  int  m_left = 0, m_drain = 0, m_adv = 0;
  bit  m_done = 0, exp_we = 0;
  logic [N*DW-1:0] ha [0:511];
  logic [N*DW-1:0] hb [0:511];
  // downstream PE array: operands flow right/down, accumulate on we
  int          acc [N][N];
  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_left = 0; m_drain = 0; m_adv = 0; m_done = 0; exp_we = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin acc[i][j] = 0; pa[i][j] = '0; pb[i][j] = '0; end
    end else begin
      bit adv_n, nd;
      logic [N*DW-1:0] ia, ib;
      logic [DW-1:0] ain, bin;
      if (we)
        for (int i = N-1; i >= 0; i--)
          for (int j = N-1; j >= 0; j--) begin
            ain = (j == 0) ? a_row[i*DW +: DW] : pa[i][j-1];
            bin = (i == 0) ? b_col[j*DW +: DW] : pb[i-1][j];
            acc[i][j] += int'(ain) * int'(bin);
            pa[i][j] = ain;
            pb[i][j] = bin;
          end
      adv_n = 0; nd = 0; ia = '0; ib = '0;
      if (m_done) begin
        nd = 0;
      end else if (m_left > 0) begin
        if (in_valid) begin
          adv_n = 1; ia = a_vec; ib = b_vec; m_left--;
          if (m_left == 0) begin
            if (N > 1) m_drain = 2*N - 2;
            else       nd = 1;
          end
        end
      end else if (m_drain > 0) begin
        adv_n = 1; m_drain--;
        if (m_drain == 0) nd = 1;
      end else if (start) begin
        if (k_len != 0) begin
          m_left = int'(k_len); m_adv = 0;
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin acc[i][j] = 0; pa[i][j] = '0; pb[i][j] = '0; end
        end else nd = 1;
      end
      if (adv_n) begin m_adv++; ha[m_adv] = ia; hb[m_adv] = ib; end
      m_done = nd;
      exp_we = adv_n;
    end
  end

  // ---------------- compare process ----------------
  int we_cnt = 0, done_cnt = 0;
  logic [N*DW-1:0] wlog [0:4095];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("we", we, exp_we);
      chk("done", done, m_done);
      chk("busy", busy, (m_left > 0) || (m_drain > 0) || m_done);
      chk("in_ready", in_ready, m_left > 0);
      if (exp_we)
        for (int i = 0; i < N; i++) begin
          int idx;
          logic [DW-1:0] ea, eb;
          idx = m_adv - i;
          ea = (idx >= 1) ? ha[idx][i*DW +: DW] : '0;
          eb = (idx >= 1) ? hb[idx][i*DW +: DW] : '0;
          chk($sformatf("a_row[%0d]@adv%0d", i, m_adv), a_row[i*DW +: DW], ea);
          chk($sformatf("b_col[%0d]@adv%0d", i, m_adv), b_col[i*DW +: DW], eb);
        end
      if (we) begin wlog[we_cnt % 4096] = a_row; we_cnt++; end
      if (done) done_cnt++;
    end
  end

  // N=1 instance monitors
  int we1_cnt = 0, done1_n = 0, done1_at = -1, acc1 = 0;
  logic [DW-1:0] w1log [0:15];
  initial forever begin
    @(negedge clk);
    if (we1) begin w1log[we1_cnt % 16] = ar1; we1_cnt++; end
    if (done1) begin done1_n++; done1_at = we1_cnt; end
  end
  initial forever begin
    @(posedge clk);
    if (we1) acc1 += int'(ar1) * int'(bc1);
  end

  // ---------------- stimulus ----------------
  logic [N*DW-1:0] pla [0:255];
  logic [N*DW-1:0] plb [0:255];
  int saved [N][N];

  task automatic fill_rand(input int k);
    for (int b = 0; b < k; b++) begin pla[b] = $urandom; plb[b] = $urandom; end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a_vec = $urandom; b_vec = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_c(input string tag, input int k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int e;
        e = 0;
        for (int b = 0; b < k; b++)
          e += int'(pla[b][i*DW +: DW]) * int'(plb[b][j*DW +: DW]);
        chk($sformatf("%s C(%0d,%0d)", tag, i, j), acc[i][j], e);
      end
  endtask

  // Runs one tile from pla/plb. stall_at/stall_len: forced gap before beat
  // stall_at; rnd: random extra gaps; restart_at: pulse start with another
  // k_len while that beat is presented; abort: reset during DRAIN.
  task automatic run_tile(input string tag, input int k, input int stall_at, input int stall_len,
                          input bit rnd, input int restart_at, input bit abort, output int we_delta);
    int sent, scnt, waited, we0;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k);
    in_valid = 1'($urandom_range(0, 1)); a_vec = $urandom; b_vec = $urandom;
    we0 = we_cnt;
    @(negedge clk);
    sent = 0; scnt = 0;
    while (sent < k) begin
      start = (sent == restart_at);
      k_len = KW'(k + 3);
      if ((sent == stall_at && scnt < stall_len) || (rnd && $urandom_range(0, 3) == 0)) begin
        if (sent == stall_at) scnt++;
        in_valid = 1'b0; a_vec = $urandom; b_vec = $urandom;
      end else begin
        in_valid = 1'b1; a_vec = pla[sent]; b_vec = plb[sent]; sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    if (abort) begin
      @(negedge clk);
      chk({tag, " busy_in_drain"}, busy, 1);
      chk({tag, " ready_in_drain"}, in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, " rst we"}, we, 0);
      chk({tag, " rst done"}, done, 0);
      chk({tag, " rst busy"}, busy, 0);
      chk({tag, " rst a_row"}, a_row, 0);
      chk({tag, " rst b_col"}, b_col, 0);
      @(negedge clk);
      rst_n = 1'b1;
      we_delta = we_cnt - we0;
      return;
    end
    waited = 0;
    while (!done && waited < 60) begin @(negedge clk); waited++; end
    chk({tag, " done_seen"}, done, 1);
    repeat (2) @(negedge clk);
    we_delta = we_cnt - we0;
    chk({tag, " we_count"}, we_delta, k + 2*N - 2);
    check_c(tag, k);
  endtask

  initial begin
    int wd, base;
    @(negedge clk);
    chk("reset we", we, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset a_row", a_row, 0);
    chk("reset b_col", b_col, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // K=1 fixed vectors
    pla[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    plb[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    base = we_cnt;
    run_tile("k1", 1, -1, 0, 0, -1, 0, wd);
    chk("k1 we7", wd, 7);
    chk("k1 lane2 third we", wlog[(base + 2) % 4096][2*DW +: DW], 3);
    chk("k1 C33", acc[3][3], 32);
    chk("k1 C00", acc[0][0], 5);
    chk("k1 C21", acc[2][1], 18);
    idle(2);

    // K=3 with a 2-cycle stall after beat 1, then same matrices unstalled
    fill_rand(3);
    run_tile("k3stall", 3, 1, 2, 0, -1, 0, wd);
    chk("k3stall we9", wd, 9);
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) saved[i][j] = acc[i][j];
    idle(2);
    run_tile("k3plain", 3, -1, 0, 0, -1, 0, wd);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk($sformatf("stall_vs_plain C(%0d,%0d)", i, j), saved[i][j], acc[i][j]);
    idle(2);

    // k_len = 0
    @(negedge clk);
    start = 1'b1; k_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("k0 busy", busy, 1);
    chk("k0 done", done, 1);
    chk("k0 ready", in_ready, 0);
    chk("k0 we", we, 0);
    @(negedge clk);
    chk("k0 busy after", busy, 0);
    chk("k0 done after", done, 0);
    idle(2);

    // start re-pulsed during FEED with a different k_len
    fill_rand(4);
    run_tile("restart", 4, -1, 0, 0, 2, 0, wd);
    idle(2);

    // reset during DRAIN, then a K=2 tile
    fill_rand(3);
    run_tile("abort", 3, -1, 0, 0, -1, 1, wd);
    idle(2);
    fill_rand(2);
    run_tile("after_rst", 2, -1, 0, 0, -1, 0, wd);
    idle(2);

    // random tiles with random stalls
    for (int t = 0; t < 6; t++) begin
      int k;
      k = $urandom_range(1, 12);
      fill_rand(k);
      run_tile($sformatf("rand%0d", t), k, -1, 0, 1, -1, 0, wd);
      idle($urandom_range(0, 3));
    end

    // maximum K
    fill_rand(255);
    run_tile("kmax", 255, -1, 0, 0, -1, 0, wd);
    idle(2);

    // N=1: five beats 1..5 times 2
    @(negedge clk);
    start1 = 1'b1; k1 = 8'd5;
    @(negedge clk);
    start1 = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      v1 = 1'b1; a1 = DW'(b); b1 = 8'd2;
      @(negedge clk);
    end
    v1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("n1 we_count", we1_cnt, 5);
    chk("n1 done_pulses", done1_n, 1);
    chk("n1 done_at_we", done1_at, 5);
    chk("n1 C", acc1, 30);
    chk("n1 busy", busy1, 0);
    for (int b = 0; b < 5; b++) chk($sformatf("n1 a_row beat%0d", b), w1log[b], b + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
